// File: rtl/apb_slave_mem.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | apb_slave_mem : APB4 completer memory, byte strobes, wait states, PSLVERR   |
// | Revision      : 1.0                                                         |
// +----------------------------------------------------------------------------+
module apb_slave_mem #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                    pclk,
  input  logic                    presetn,
  input  logic                    psel,
  input  logic                    penable,
  input  logic                    pwrite,
  input  logic [ADDR_WIDTH-1:0]   paddr,
  input  logic [DATA_WIDTH-1:0]   pwdata,
  input  logic [DATA_WIDTH/8-1:0] pstrb,
  output logic [DATA_WIDTH-1:0]   prdata,
  output logic                    pready,
  output logic                    pslverr
);

  localparam int c_NB  = DATA_WIDTH / 8;
  localparam int c_LSB = $clog2(c_NB);
  localparam int c_MAW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_CW  = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_ACCESS = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [c_CW-1:0]       r_cnt;
  logic [c_MAW-1:0]      r_idx;
  logic                  r_write;
  logic                  r_err;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [c_NB-1:0]       r_strb;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic [ADDR_WIDTH-1:0] w_idx;
  logic                  w_misalign;
  logic                  w_err;
  logic                  w_setup;
  logic                  w_ready;

  assign w_idx = paddr >> c_LSB;

  generate
    if (c_LSB > 0) begin : g_lsb
      assign w_misalign = |paddr[c_LSB-1:0];
    end else begin : g_no_lsb
      assign w_misalign = 1'b0;
    end
  endgenerate

  assign w_err   = w_misalign || (32'(w_idx) >= 32'(DEPTH));
  assign w_setup = (r_state == S_IDLE) && psel && !penable;
  assign w_ready = (r_state == S_ACCESS) && (r_cnt == '0) && psel && penable;

  assign pready  = w_ready;
  assign pslverr = w_ready && r_err;
  assign prdata  = r_rdata;

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Dropping psel mid-access abandons the transfer without completing it.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_setup) begin
          w_next = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (!psel || w_ready) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      r_cnt   <= '0;
      r_idx   <= '0;
      r_write <= 1'b0;
      r_err   <= 1'b0;
      r_wdata <= '0;
      r_strb  <= '0;
      r_rdata <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_setup) begin
        r_idx   <= w_idx[c_MAW-1:0];
        r_write <= pwrite;
        r_err   <= w_err;
        r_wdata <= pwdata;
        r_strb  <= pstrb;
        r_cnt   <= c_CW'(WAIT_CYCLES);
        if (!pwrite && !w_err) begin
          r_rdata <= r_mem[w_idx[c_MAW-1:0]];
        end else begin
          r_rdata <= '0;
        end
      end else if ((r_state == S_ACCESS) && psel && penable && (r_cnt != '0)) begin
        r_cnt <= r_cnt - 1'b1;
      end

      if (w_ready && r_write && !r_err) begin
        for (int i = 0; i < c_NB; i++) begin
          if (r_strb[i]) begin
            r_mem[r_idx][i*8 +: 8] <= r_wdata[i*8 +: 8];
          end
        end
      end
    end
  end

endmodule
`default_nettype wire
